// File: rtl/hazard_fwd_unit.sv
// Operand bypass selection, store-data forwarding, and load-use / multi-cycle
// hazard detection backed by an in-order fixed-latency scoreboard.
module hazard_fwd_unit #(
    parameter  int unsigned RW         = 5,
    parameter  int unsigned NUM_SRC    = 2,
    parameter  int unsigned FWD_STAGES = 2,
    parameter  int unsigned MC_LAT     = 4,
    parameter  int unsigned MC_DEPTH   = 2,
    localparam int unsigned SEL_W      = $clog2(FWD_STAGES + 1),
    localparam int unsigned CW         = $clog2(MC_LAT + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*RW-1:0]      ex_rs,
    input  logic [NUM_SRC-1:0]         ex_src_en,
    input  logic [FWD_STAGES-1:0]      stg_regwr,
    input  logic [FWD_STAGES*RW-1:0]   stg_rd,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    input  logic                       mem_memwr,
    input  logic [RW-1:0]              mem_rt,
    output logic                       memdata_fwd,
    input  logic                       ex_is_load,
    input  logic                       ex_regwr,
    input  logic [RW-1:0]              ex_rd,
    input  logic                       id_valid,
    input  logic [NUM_SRC*RW-1:0]      id_rs,
    input  logic [NUM_SRC-1:0]         id_src_en,
    input  logic                       id_regwr,
    input  logic [RW-1:0]              id_rd,
    input  logic                       id_mc,
    output logic                       stall,
    output logic                       bubble,
    output logic                       mc_full,
    output logic                       mc_done,
    output logic [RW-1:0]              mc_done_rd,
    output logic [15:0]                stall_cnt
);

    localparam int unsigned WB = FWD_STAGES - 1;
    localparam int unsigned PW = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1;

    typedef enum logic [1:0] {
        RUN,
        LD_STALL,
        MC_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic [MC_DEPTH-1:0] sb_vld_q, sb_vld_d;
    logic [RW-1:0]       sb_rd_q  [MC_DEPTH];
    logic [RW-1:0]       sb_rd_d  [MC_DEPTH];
    logic [CW-1:0]       sb_cnt_q [MC_DEPTH];
    logic [CW-1:0]       sb_cnt_d [MC_DEPTH];
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;

    logic head_done;
    logic ld_haz;
    logic mc_haz;
    logic alloc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MC_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Walk stages oldest to youngest so the youngest match overwrites.
    always_comb begin
        fwd_sel = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            for (int unsigned k = FWD_STAGES; k > 0; k--) begin
                if (ex_src_en[s] && stg_regwr[k-1] &&
                    (stg_rd[(k-1)*RW +: RW] != '0) &&
                    (stg_rd[(k-1)*RW +: RW] == ex_rs[s*RW +: RW])) begin
                    fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    assign memdata_fwd = mem_memwr & stg_regwr[WB] & (mem_rt != '0) &
                         (stg_rd[WB*RW +: RW] == mem_rt);

    assign head_done  = sb_vld_q[head_q] & (sb_cnt_q[head_q] == CW'(1));
    assign mc_full    = &sb_vld_q;
    assign mc_done    = head_done;
    assign mc_done_rd = head_done ? sb_rd_q[head_q] : '0;

    always_comb begin
        ld_haz = 1'b0;
        if (ex_is_load && ex_regwr && (ex_rd != '0)) begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                if (id_src_en[s] && (id_rs[s*RW +: RW] == ex_rd)) begin
                    ld_haz = 1'b1;
                end
            end
        end
    end

    // A completing entry still blocks: its result lands only at this edge.
    always_comb begin
        mc_haz = id_mc & mc_full & ~head_done;
        for (int unsigned e = 0; e < MC_DEPTH; e++) begin
            if (sb_vld_q[e] && (sb_rd_q[e] != '0)) begin
                if (id_regwr && (id_rd == sb_rd_q[e])) begin
                    mc_haz = 1'b1;
                end
                for (int unsigned s = 0; s < NUM_SRC; s++) begin
                    if (id_src_en[s] && (id_rs[s*RW +: RW] == sb_rd_q[e])) begin
                        mc_haz = 1'b1;
                    end
                end
            end
        end
    end

    assign stall     = id_valid & (ld_haz | mc_haz);
    assign bubble    = stall;
    assign alloc     = id_valid & ~stall & id_mc;
    assign stall_cnt = stall_cnt_q;

    // Free precedes alloc so a full queue can retire and refill one slot.
    always_comb begin
        sb_vld_d = sb_vld_q;
        sb_rd_d  = sb_rd_q;
        sb_cnt_d = sb_cnt_q;
        head_d   = head_q;
        tail_d   = tail_q;
        for (int unsigned e = 0; e < MC_DEPTH; e++) begin
            if (sb_vld_q[e] && (sb_cnt_q[e] > CW'(1))) begin
                sb_cnt_d[e] = sb_cnt_q[e] - CW'(1);
            end
        end
        if (head_done) begin
            sb_vld_d[head_q] = 1'b0;
            head_d           = ptr_inc(head_q);
        end
        if (alloc) begin
            sb_vld_d[tail_q] = 1'b1;
            sb_rd_d[tail_q]  = id_rd;
            sb_cnt_d[tail_q] = CW'(MC_LAT);
            tail_d           = ptr_inc(tail_q);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mc_haz) begin
                    state_d = MC_WAIT;
                end else if (ld_haz) begin
                    state_d = LD_STALL;
                end
            end
            LD_STALL: state_d = RUN;
            MC_WAIT: begin
                if (!mc_haz) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            sb_vld_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            stall_cnt_q <= '0;
            for (int unsigned e = 0; e < MC_DEPTH; e++) begin
                sb_rd_q[e]  <= '0;
                sb_cnt_q[e] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sb_vld_q    <= sb_vld_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            stall_cnt_q <= stall_cnt_d;
            sb_rd_q     <= sb_rd_d;
            sb_cnt_q    <= sb_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Random and directed stimulus for hazard_fwd_unit, checked against a
// queue-of-deadlines model of the multi-cycle unit and rule-based forwarding.
module tb_hazard_fwd_unit;

    localparam int unsigned RW         = 5;
    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned FWD_STAGES = 2;
    localparam int unsigned MC_LAT     = 4;
    localparam int unsigned MC_DEPTH   = 2;
    localparam int unsigned SEL_W      = $clog2(FWD_STAGES + 1);

    logic                     clk;
    logic                     rst_n;
    logic [NUM_SRC*RW-1:0]    ex_rs;
    logic [NUM_SRC-1:0]       ex_src_en;
    logic [FWD_STAGES-1:0]    stg_regwr;
    logic [FWD_STAGES*RW-1:0] stg_rd;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     mem_memwr;
    logic [RW-1:0]            mem_rt;
    logic                     memdata_fwd;
    logic                     ex_is_load;
    logic                     ex_regwr;
    logic [RW-1:0]            ex_rd;
    logic                     id_valid;
    logic [NUM_SRC*RW-1:0]    id_rs;
    logic [NUM_SRC-1:0]       id_src_en;
    logic                     id_regwr;
    logic [RW-1:0]            id_rd;
    logic                     id_mc;
    logic                     stall;
    logic                     bubble;
    logic                     mc_full;
    logic                     mc_done;
    logic [RW-1:0]            mc_done_rd;
    logic [15:0]              stall_cnt;

    hazard_fwd_unit #(
        .RW(RW), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES),
        .MC_LAT(MC_LAT), .MC_DEPTH(MC_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_rs(ex_rs), .ex_src_en(ex_src_en),
        .stg_regwr(stg_regwr), .stg_rd(stg_rd), .fwd_sel(fwd_sel),
        .mem_memwr(mem_memwr), .mem_rt(mem_rt), .memdata_fwd(memdata_fwd),
        .ex_is_load(ex_is_load), .ex_regwr(ex_regwr), .ex_rd(ex_rd),
        .id_valid(id_valid), .id_rs(id_rs), .id_src_en(id_src_en),
        .id_regwr(id_regwr), .id_rd(id_rd), .id_mc(id_mc),
        .stall(stall), .bubble(bubble), .mc_full(mc_full),
        .mc_done(mc_done), .mc_done_rd(mc_done_rd), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each in-flight op retires in the cycle whose upcoming edge number equals due.
    typedef struct {
        logic [RW-1:0] rd;
        int unsigned   due;
    } mc_op_t;

    mc_op_t      mq[$];
    int unsigned edge_no;
    int unsigned m_cnt;
    int          n_tests;
    int          n_fail;
    bit          checks_on;
    logic        obs_stall;
    logic        obs_done;
    logic [RW-1:0] obs_done_rd;
    logic [15:0] obs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int unsigned exp_fwd(input int s);
        if (!ex_src_en[s]) return 0;
        for (int k = 0; k < FWD_STAGES; k++) begin
            if (stg_regwr[k] && stg_rd[k*RW +: RW] != 0 && stg_rd[k*RW +: RW] == ex_rs[s*RW +: RW])
                return k + 1;
        end
        return 0;
    endfunction

    task automatic step();
        bit            hd;
        bit            full;
        bit            mch;
        bit            lde;
        bit            st;
        bit            mfw;
        logic [RW-1:0] drd;
        mc_op_t        op;
        @(negedge clk);
        hd   = (mq.size() > 0) && (mq[0].due == edge_no);
        full = (mq.size() == MC_DEPTH);
        mch  = id_mc && full && !hd;
        foreach (mq[i]) begin
            if (mq[i].rd != 0) begin
                if (id_regwr && id_rd == mq[i].rd) mch = 1;
                for (int s = 0; s < NUM_SRC; s++)
                    if (id_src_en[s] && id_rs[s*RW +: RW] == mq[i].rd) mch = 1;
            end
        end
        lde = 0;
        if (ex_is_load && ex_regwr && ex_rd != 0)
            for (int s = 0; s < NUM_SRC; s++)
                if (id_src_en[s] && id_rs[s*RW +: RW] == ex_rd) lde = 1;
        st  = id_valid && (lde || mch);
        drd = hd ? mq[0].rd : '0;
        mfw = mem_memwr && stg_regwr[FWD_STAGES-1] && mem_rt != 0 &&
              stg_rd[(FWD_STAGES-1)*RW +: RW] == mem_rt;
        obs_stall   = stall;
        obs_done    = mc_done;
        obs_done_rd = mc_done_rd;
        obs_cnt     = stall_cnt;
        if (checks_on) begin
            for (int s = 0; s < NUM_SRC; s++)
                chk($sformatf("fwd_sel%0d", s), 32'(fwd_sel[s*SEL_W +: SEL_W]), exp_fwd(s));
            chk("memdata_fwd", 32'(memdata_fwd), 32'(mfw));
            chk("stall", 32'(stall), 32'(st));
            chk("bubble", 32'(bubble), 32'(st));
            chk("mc_full", 32'(mc_full), 32'(full));
            chk("mc_done", 32'(mc_done), 32'(hd));
            chk("mc_done_rd", 32'(mc_done_rd), 32'(drd));
            chk("stall_cnt", 32'(stall_cnt), m_cnt);
        end
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            if (hd) void'(mq.pop_front());
            if (id_valid && !st && id_mc) begin
                op.rd  = id_rd;
                op.due = edge_no + MC_LAT;
                mq.push_back(op);
            end
            if (st && m_cnt != 32'hFFFF) m_cnt++;
        end
        edge_no++;
        #1;
    endtask

    task automatic clear_inputs();
        rst_n = 1'b1; ex_rs = '0; ex_src_en = '0; stg_regwr = '0; stg_rd = '0;
        mem_memwr = 1'b0; mem_rt = '0; ex_is_load = 1'b0; ex_regwr = 1'b0; ex_rd = '0;
        id_valid = 1'b0; id_rs = '0; id_src_en = '0; id_regwr = 1'b0; id_rd = '0; id_mc = 1'b0;
    endtask

    task automatic rand_inputs();
        for (int s = 0; s < NUM_SRC; s++) begin
            ex_rs[s*RW +: RW] = RW'($urandom_range(0, 3));
            id_rs[s*RW +: RW] = RW'($urandom_range(0, 3));
        end
        for (int k = 0; k < FWD_STAGES; k++) stg_rd[k*RW +: RW] = RW'($urandom_range(0, 3));
        ex_src_en  = NUM_SRC'($urandom);
        id_src_en  = NUM_SRC'($urandom);
        stg_regwr  = FWD_STAGES'($urandom);
        mem_memwr  = 1'($urandom);
        mem_rt     = RW'($urandom_range(0, 3));
        ex_is_load = ($urandom_range(0, 2) == 0);
        ex_regwr   = 1'($urandom);
        ex_rd      = RW'($urandom_range(0, 3));
        id_valid   = ($urandom_range(0, 7) != 0);
        id_regwr   = 1'($urandom);
        id_rd      = RW'($urandom_range(0, 3));
        id_mc      = ($urandom_range(0, 3) == 0);
        rst_n      = ($urandom_range(0, 80) != 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; edge_no = 0; m_cnt = 0; checks_on = 0;
        clear_inputs();
        rst_n = 1'b0;
        step(); step();
        checks_on = 1;
        rst_n = 1'b1;
        step();
        chk("reset_stall_cnt", 32'(obs_cnt), 32'd0);

        // Forwarding priority and enable.
        stg_regwr = 2'b11; stg_rd = {5'd5, 5'd5}; ex_rs[RW-1:0] = 5'd5; ex_src_en = 2'b01;
        step();
        stg_rd[RW-1:0] = 5'd0;
        step();
        ex_src_en = 2'b00;
        step();

        // Store data from WB.
        clear_inputs();
        mem_memwr = 1'b1; mem_rt = 5'd3; stg_rd[(FWD_STAGES-1)*RW +: RW] = 5'd3;
        step();
        stg_regwr[FWD_STAGES-1] = 1'b1;
        step();
        mem_rt = 5'd0;
        step();

        // Load-use: one stalled cycle, then the load has moved on.
        clear_inputs();
        ex_is_load = 1'b1; ex_regwr = 1'b1; ex_rd = 5'd8;
        id_valid = 1'b1; id_rs[RW +: RW] = 5'd8; id_src_en = 2'b10;
        step();
        chk("ld_stall", 32'(obs_stall), 32'd1);
        ex_is_load = 1'b0; ex_regwr = 1'b0; ex_rd = 5'd0;
        step();
        chk("ld_release", 32'(obs_stall), 32'd0);

        // Multi-cycle latency: stalls for cycles 1..4, done with rd=9 in cycle 4.
        clear_inputs();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        id_valid = 1'b1; id_mc = 1'b1; id_regwr = 1'b1; id_rd = 5'd9;
        step();
        id_mc = 1'b0; id_regwr = 1'b0; id_rd = 5'd0; id_rs[RW-1:0] = 5'd9; id_src_en = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("mc_seq_stall_c%0d", c), 32'(obs_stall), 32'(c <= 4));
            chk($sformatf("mc_seq_done_c%0d", c), 32'(obs_done), 32'(c == 4));
        end
        chk("mc_seq_done_rd", 32'(obs_done_rd), 32'd0);

        // Full scoreboard: third mc op waits for the head to retire.
        clear_inputs();
        id_valid = 1'b1; id_mc = 1'b1; id_regwr = 1'b1;
        id_rd = 5'd10; step();
        id_rd = 5'd11; step();
        id_rd = 5'd12;
        for (int c = 0; c < 6; c++) step();

        // Reset while waiting on a multi-cycle result.
        clear_inputs();
        id_valid = 1'b1; id_mc = 1'b1; id_regwr = 1'b1; id_rd = 5'd7; step();
        id_mc = 1'b0; id_regwr = 1'b0; id_rs[RW-1:0] = 5'd7; id_src_en = 2'b01;
        step(); step();
        rst_n = 1'b0; step();
        rst_n = 1'b1; step();
        chk("rst_wait_stall", 32'(obs_stall), 32'd0);
        chk("rst_wait_cnt", 32'(obs_cnt), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
